// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem read per PC and holds the word for decode.
// Optional stall-cycle counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int            n         = 32,
    parameter logic [n-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic [n-1:0] pc,
    output logic         pc_we,
    input  logic         flush,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_rvalid,
    input  logic [n-1:0] imem_rdata,
    output logic         if_valid,
    output logic [n-1:0] if_instr,
    output logic [n-1:0] if_pc,
    input  logic         id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_VALID
    } state_t;

    state_t       state_q, state_d;
    logic         if_valid_q, if_valid_d;
    logic [n-1:0] if_instr_q, if_instr_d;
    logic [n-1:0] if_pc_q, if_pc_d;
    logic [n-1:0] req_addr_q, req_addr_d;

    // State, holding register and request address flops
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= '0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state and output decode; outputs forced low during reset
    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        req_addr_d = req_addr_q;
        pc_we      = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = '0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                pc_we = flush;
                if (!flush) begin
                    imem_req   = 1'b1;
                    imem_addr  = pc;
                    req_addr_d = pc;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                pc_we = flush;
                if (flush) begin
                    state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_addr_q;
                    if_valid_d = 1'b1;
                    state_d    = S_VALID;
                end
            end
            S_DRAIN: begin
                pc_we = flush;
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            S_VALID: begin
                pc_we = flush | id_ready;
                if (flush) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = S_FETCH;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rst) begin
            pc_we     = 1'b0;
            imem_req  = 1'b0;
            imem_addr = '0;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles with a read outstanding; wraps naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_WAIT || state_q == S_DRAIN) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Stall counter checks run when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'hFFFF_FFF0;
    logic        pc_we;
    logic        flush = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b1;
    logic [31:0] imem_rdata = 32'hCAFE_F00D;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    fetch_unit dut (
        .CLK(CLK),
        .rst(rst),
        .pc(pc),
        .pc_we(pc_we),
        .flush(flush),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc),
        .id_ready(id_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt(fetch_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts in FETCH; ends one cycle into VALID with the word checked.
    task automatic serve(input logic [31:0] a, input logic [31:0] d,
                         input int lat);
        pc = a;
        #1;
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, a);
        chk("fetch_pcwe", {31'b0, pc_we}, 32'd0);
        step();
        for (int i = 1; i < lat; i++) begin
            chk("wait_req", {31'b0, imem_req}, 32'd0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        #1;
        chk("wait_req", {31'b0, imem_req}, 32'd0);
        chk("wait_pcwe", {31'b0, pc_we}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("valid", {31'b0, if_valid}, 32'd1);
        chk("instr", if_instr, d);
        chk("ifpc", if_pc, a);
    endtask

    initial begin
        // 1: reset with junk inputs
        #1;
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pcwe", {31'b0, pc_we}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        step();
        step();
        chk("rst_valid2", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h13);
        chk("rst_pcwe2", {31'b0, pc_we}, 32'd0);
        chk("rst_req2", {31'b0, imem_req}, 32'd0);
        chk("rst_ifpc", if_pc, 32'h0);
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b1;
        pc          = 32'h0;
        rst         = 1'b0;
        #1;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        chk("idle_pcwe", {31'b0, pc_we}, 32'd0);
        step();

        // 2: streaming with 1-cycle memory and id_ready held high
        for (int k = 0; k < 3; k++) begin
            serve(32'(4 * k), 32'h1000_0000 + 32'(k), 1);
            chk("stream_pcwe", {31'b0, pc_we}, 32'd1);
            step();
            #1;
            chk("stream_drop", {31'b0, if_valid}, 32'd0);
        end

        // 3: decode stall for 5 cycles
        id_ready = 1'b0;
        serve(32'h0000_000C, 32'hAAAA_5555, 2);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_instr", if_instr, 32'hAAAA_5555);
            chk("stall_ifpc", if_pc, 32'h0000_000C);
            chk("stall_pcwe", {31'b0, pc_we}, 32'd0);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            step();
        end
        id_ready = 1'b1;
        #1;
        chk("release_pcwe", {31'b0, pc_we}, 32'd1);
        step();
        id_ready = 1'b0;
        #1;
        chk("release_pcwe_off", {31'b0, pc_we}, 32'd0);
        chk("release_valid", {31'b0, if_valid}, 32'd0);

        // flush while in FETCH: no request, PC reloads, stay in FETCH
        pc    = 32'h10;
        flush = 1'b1;
        #1;
        chk("ffetch_req", {31'b0, imem_req}, 32'd0);
        chk("ffetch_pcwe", {31'b0, pc_we}, 32'd1);
        step();
        flush = 1'b0;

        // 4: flush in WAIT with 3-cycle memory, late data dropped
        pc = 32'h20;
        #1;
        chk("f4_req", {31'b0, imem_req}, 32'd1);
        chk("f4_addr", imem_addr, 32'h20);
        step();
        #1;
        chk("f4_wait_req", {31'b0, imem_req}, 32'd0);
        step();
        flush = 1'b1;
        #1;
        chk("f4_flush_pcwe", {31'b0, pc_we}, 32'd1);
        chk("f4_flush_req", {31'b0, imem_req}, 32'd0);
        step();
        flush       = 1'b0;
        pc          = 32'h100;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("drain_req", {31'b0, imem_req}, 32'd0);
        chk("drain_pcwe", {31'b0, pc_we}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("post_drain_req", {31'b0, imem_req}, 32'd1);
        chk("post_drain_addr", imem_addr, 32'h100);
        chk("post_drain_valid", {31'b0, if_valid}, 32'd0);
        chk("post_drain_instr", if_instr, 32'hAAAA_5555);
        serve(32'h100, 32'h0050_0093, 1);

        // 5: flush and id_ready together in VALID
        flush    = 1'b1;
        id_ready = 1'b1;
        #1;
        chk("f5_pcwe", {31'b0, pc_we}, 32'd1);
        step();
        flush    = 1'b0;
        id_ready = 1'b0;
        pc       = 32'h200;
        #1;
        chk("f5_valid", {31'b0, if_valid}, 32'd0);
        chk("f5_instr", if_instr, 32'h13);
        chk("f5_req", {31'b0, imem_req}, 32'd1);
        chk("f5_addr", imem_addr, 32'h200);
        chk("f5_pcwe_off", {31'b0, pc_we}, 32'd0);

        // flush coinciding with rvalid in WAIT: data discarded, back to FETCH
        step();
        flush       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        #1;
        chk("fr_pcwe", {31'b0, pc_we}, 32'd1);
        step();
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pc          = 32'h300;
        #1;
        chk("fr_req", {31'b0, imem_req}, 32'd1);
        chk("fr_addr", imem_addr, 32'h300);
        chk("fr_instr", if_instr, 32'h13);
        chk("fr_valid", {31'b0, if_valid}, 32'd0);
        serve(32'h300, 32'h1234_5678, 1);

        // 6: stall counter and async reset mid-WAIT
        rst = 1'b1;
        #1;
        chk("r6_valid", {31'b0, if_valid}, 32'd0);
        chk("r6_instr", if_instr, 32'h13);
`ifdef FETCH_PERF_CNT_EN
        chk("r6_cnt0", fetch_stall_cnt, 32'd0);
`endif
        rst      = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("r6_idle_req", {31'b0, imem_req}, 32'd0);
        step();
        serve(32'h0, 32'h0000_0001, 4);
        step();
        serve(32'h4, 32'h0000_0002, 4);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt8", fetch_stall_cnt, 32'd8);
`endif
        step();
        pc = 32'h8;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("r6_mid_req", {31'b0, imem_req}, 32'd0);
        chk("r6_mid_pcwe", {31'b0, pc_we}, 32'd0);
        chk("r6_mid_valid", {31'b0, if_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("r6_mid_cnt", fetch_stall_cnt, 32'd0);
`endif
        step();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("r6_idle2_req", {31'b0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("r6_fetch_req", {31'b0, imem_req}, 32'd1);
        chk("r6_fetch_addr", imem_addr, 32'h8);
        chk("r6_fetch_valid", {31'b0, if_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
